// File: rtl/regbank_write_arbiter.sv
// Write-port arbiter for the register bank: merges pipeline writeback with
// late multi-cycle results (buffered in a small FIFO) and tracks busy
// destination registers so decode can hold on a hazard.
module regbank_write_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_we,
  input  logic [3:0]                 wb_addr,
  input  logic [31:0]                wb_data,
  input  logic                       issue_valid,
  input  logic [3:0]                 issue_addr,
  input  logic                       ret_valid,
  output logic                       ret_ready,
  input  logic [3:0]                 ret_addr,
  input  logic [31:0]                ret_data,
  input  logic [3:0]                 rd_addr_a,
  input  logic [3:0]                 rd_addr_b,
  input  logic [3:0]                 rd_addr_d,
  output logic                       hazard,
  output logic [3:0]                 addr_d,
  output logic [31:0]                data_d,
  output logic                       we,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [3:0]    fifo_addr_q [DEPTH];
  logic [3:0]    fifo_addr_d [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [PW-1:0] count_q, count_d;
  logic [15:0]   busy_q, busy_d;

  logic          wb_req;
  logic          fifo_empty;
  logic          ret_acc;
  logic          pop;
  logic          bypass;
  logic          push;
  logic [15:0]   busy_set;
  logic [15:0]   busy_clr;

  // Arbitration, FIFO bookkeeping, busy mask and hazard; reset forces outputs low
  always_comb begin
    we          = 1'b0;
    addr_d      = 4'd0;
    data_d      = 32'd0;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    busy_set    = 16'd0;
    busy_clr    = 16'd0;

    wb_req     = wb_we && (wb_addr != 4'd0);
    fifo_empty = (count_q == PW'(0));
    ret_ready  = !reset && (count_q < PW'(DEPTH));
    // Returns to r0 are accepted but neither written nor buffered
    ret_acc    = ret_valid && ret_ready && (ret_addr != 4'd0);
    pop        = !reset && !wb_req && !fifo_empty;
    bypass     = !reset && !wb_req && fifo_empty && ret_acc;
    push       = ret_acc && !bypass;

    if (!reset) begin
      if (wb_req) begin
        we     = 1'b1;
        addr_d = wb_addr;
        data_d = wb_data;
      end else if (pop) begin
        we     = 1'b1;
        addr_d = fifo_addr_q[head_q];
        data_d = fifo_data_q[head_q];
      end else if (bypass) begin
        we     = 1'b1;
        addr_d = ret_addr;
        data_d = ret_data;
      end
    end

    if (pop) begin
      busy_clr[fifo_addr_q[head_q]] = 1'b1;
      head_d = head_q + AW'(1);
    end
    if (bypass) begin
      busy_clr[ret_addr] = 1'b1;
    end
    if (push) begin
      fifo_addr_d[tail_q] = ret_addr;
      fifo_data_d[tail_q] = ret_data;
      tail_d = tail_q + AW'(1);
    end
    count_d = count_q + PW'(push) - PW'(pop);

    if (issue_valid && (issue_addr != 4'd0)) begin
      busy_set[issue_addr] = 1'b1;
    end
    // Set wins over a same-cycle clear of the same register
    busy_d = (busy_q & ~busy_clr) | busy_set;

    hazard = !reset && (
               (busy_q[rd_addr_a] && (rd_addr_a != 4'd0)) ||
               (busy_q[rd_addr_b] && (rd_addr_b != 4'd0)) ||
               (busy_q[rd_addr_d] && (rd_addr_d != 4'd0)));

    pending = count_q;
  end

  // State registers with synchronous reset that discards buffered results
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_addr_q[i] <= 4'd0;
        fifo_data_q[i] <= 32'd0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: inputs change on the falling
// edge, outputs are checked 1ns later, well before the next rising edge.
module tb_regbank_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic        ret_valid;
  logic        ret_ready;
  logic [3:0]  ret_addr;
  logic [31:0] ret_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [3:0]  rd_addr_d;
  logic        hazard;
  logic [3:0]  addr_d;
  logic [31:0] data_d;
  logic        we;
  logic [1:0]  pending;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] tb_busy = 16'd0;

  always #5 clk = ~clk;

  regbank_write_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_addr(ret_addr), .ret_data(ret_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_d(rd_addr_d),
    .hazard(hazard), .addr_d(addr_d), .data_d(data_d), .we(we),
    .pending(pending)
  );

  // Protocol guard: never issue to a register whose late result is still outstanding
  always @(posedge clk) begin
    if (reset) begin
      tb_busy <= 16'd0;
    end else begin
      if (issue_valid && issue_addr != 4'd0 && tb_busy[issue_addr])
        $error("protocol violation: issue to busy r%0d", issue_addr);
      if (we && !(wb_we && wb_addr != 4'd0))
        tb_busy[addr_d] <= 1'b0;
      if (issue_valid && issue_addr != 4'd0)
        tb_busy[issue_addr] <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge with all requests idle
  task automatic next_cycle();
    @(negedge clk);
    wb_we = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
    issue_valid = 1'b0; issue_addr = 4'd0;
    ret_valid = 1'b0; ret_addr = 4'd0; ret_data = 32'd0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb_we = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
    issue_valid = 1'b0; issue_addr = 4'd0;
    ret_valid = 1'b0; ret_addr = 4'd0; ret_data = 32'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0; rd_addr_d = 4'd0;

    // Reset forcing
    ret_valid = 1'b1; ret_addr = 4'd3; wb_we = 1'b1; wb_addr = 4'd2;
    settle();
    check_val("rst_we", 32'(we), 32'd0);
    check_val("rst_ret_ready", 32'(ret_ready), 32'd0);
    check_val("rst_addr_d", 32'(addr_d), 32'd0);
    next_cycle();
    reset = 1'b0;
    settle();
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_hazard", 32'(hazard), 32'd0);

    // Pipeline only
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = 32'h12345678;
    settle();
    check_val("wb_we", 32'(we), 32'd1);
    check_val("wb_addr", 32'(addr_d), 32'd5);
    check_val("wb_data", data_d, 32'h12345678);
    next_cycle();
    wb_we = 1'b1; wb_addr = 4'd0; wb_data = 32'h55;
    settle();
    check_val("wb_r0_we", 32'(we), 32'd0);

    // Bypass of a return when FIFO empty
    next_cycle();
    ret_valid = 1'b1; ret_addr = 4'd3; ret_data = 32'hDEAD;
    settle();
    check_val("byp_we", 32'(we), 32'd1);
    check_val("byp_addr", 32'(addr_d), 32'd3);
    check_val("byp_data", data_d, 32'hDEAD);
    check_val("byp_ready", 32'(ret_ready), 32'd1);
    next_cycle();
    settle();
    check_val("byp_pending", 32'(pending), 32'd0);
    check_val("byp_idle_we", 32'(we), 32'd0);

    // Return to r0 is accepted and dropped
    ret_valid = 1'b1; ret_addr = 4'd0; ret_data = 32'h77;
    settle();
    check_val("r0_ret_ready", 32'(ret_ready), 32'd1);
    check_val("r0_ret_we", 32'(we), 32'd0);
    next_cycle();
    settle();
    check_val("r0_ret_pending", 32'(pending), 32'd0);

    // Collision: wb wins, return is buffered then drained
    wb_we = 1'b1; wb_addr = 4'd1; wb_data = 32'hA;
    ret_valid = 1'b1; ret_addr = 4'd2; ret_data = 32'hB;
    settle();
    check_val("col_addr", 32'(addr_d), 32'd1);
    check_val("col_data", data_d, 32'hA);
    check_val("col_ready", 32'(ret_ready), 32'd1);
    next_cycle();
    settle();
    check_val("col_pending1", 32'(pending), 32'd1);
    check_val("col_drain_we", 32'(we), 32'd1);
    check_val("col_drain_addr", 32'(addr_d), 32'd2);
    check_val("col_drain_data", data_d, 32'hB);
    next_cycle();
    settle();
    check_val("col_pending0", 32'(pending), 32'd0);
    check_val("col_idle_we", 32'(we), 32'd0);

    // Backpressure: wb held 4 cycles while r7, r8, r9 return
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      wb_we = 1'b1; wb_addr = 4'd10; wb_data = 32'(c);
      ret_valid = 1'b1;
      ret_addr = (c == 0) ? 4'd7 : (c == 1) ? 4'd8 : 4'd9;
      ret_data = (c == 0) ? 32'h70 : (c == 1) ? 32'h80 : 32'h90;
      settle();
      check_val("bp_wb_addr", 32'(addr_d), 32'd10);
      check_val("bp_pending", 32'(pending), (c == 0) ? 32'd0 : (c == 1) ? 32'd1 : 32'd2);
      check_val("bp_ready", 32'(ret_ready), (c < 2) ? 32'd1 : 32'd0);
    end
    next_cycle();
    ret_valid = 1'b1; ret_addr = 4'd9; ret_data = 32'h90;
    settle();
    check_val("bp_w7_addr", 32'(addr_d), 32'd7);
    check_val("bp_w7_data", data_d, 32'h70);
    check_val("bp_w7_ready", 32'(ret_ready), 32'd0);
    next_cycle();
    ret_valid = 1'b1; ret_addr = 4'd9; ret_data = 32'h90;
    settle();
    check_val("bp_w8_ready", 32'(ret_ready), 32'd1);
    check_val("bp_w8_addr", 32'(addr_d), 32'd8);
    check_val("bp_w8_data", data_d, 32'h80);
    next_cycle();
    settle();
    check_val("bp_w9_pending", 32'(pending), 32'd1);
    check_val("bp_w9_addr", 32'(addr_d), 32'd9);
    check_val("bp_w9_data", data_d, 32'h90);
    next_cycle();
    settle();
    check_val("bp_end_pending", 32'(pending), 32'd0);
    check_val("bp_end_we", 32'(we), 32'd0);

    // Scoreboard hazard on r4
    issue_valid = 1'b1; issue_addr = 4'd4; rd_addr_a = 4'd4;
    settle();
    check_val("sb_issue_hazard", 32'(hazard), 32'd0);
    next_cycle();
    settle();
    check_val("sb_hazard_a", 32'(hazard), 32'd1);
    rd_addr_a = 4'd0; rd_addr_d = 4'd4;
    settle();
    check_val("sb_hazard_d", 32'(hazard), 32'd1);
    rd_addr_d = 4'd0; rd_addr_b = 4'd5;
    settle();
    check_val("sb_other_reg", 32'(hazard), 32'd0);
    rd_addr_b = 4'd0; rd_addr_a = 4'd4;
    next_cycle();
    wb_we = 1'b1; wb_addr = 4'd11; wb_data = 32'h11;
    ret_valid = 1'b1; ret_addr = 4'd4; ret_data = 32'h44;
    settle();
    check_val("sb_buffered_hazard", 32'(hazard), 32'd1);
    next_cycle();
    settle();
    check_val("sb_write_addr", 32'(addr_d), 32'd4);
    check_val("sb_write_data", data_d, 32'h44);
    check_val("sb_write_hazard", 32'(hazard), 32'd1);
    next_cycle();
    settle();
    check_val("sb_after_hazard", 32'(hazard), 32'd0);
    rd_addr_a = 4'd0;

    // Reset mid-flight: two buffered results and r6 busy
    wb_we = 1'b1; wb_addr = 4'd12; wb_data = 32'h12;
    ret_valid = 1'b1; ret_addr = 4'd13; ret_data = 32'h13;
    issue_valid = 1'b1; issue_addr = 4'd6;
    next_cycle();
    wb_we = 1'b1; wb_addr = 4'd12; wb_data = 32'h12;
    ret_valid = 1'b1; ret_addr = 4'd14; ret_data = 32'h14;
    next_cycle();
    rd_addr_a = 4'd6;
    wb_we = 1'b1; wb_addr = 4'd12;
    settle();
    check_val("mr_pending", 32'(pending), 32'd2);
    check_val("mr_hazard", 32'(hazard), 32'd1);
    next_cycle();
    reset = 1'b1;
    ret_valid = 1'b1; ret_addr = 4'd15; ret_data = 32'h15;
    settle();
    check_val("mr_rst_we", 32'(we), 32'd0);
    check_val("mr_rst_ready", 32'(ret_ready), 32'd0);
    check_val("mr_rst_hazard", 32'(hazard), 32'd0);
    check_val("mr_rst_data", data_d, 32'd0);
    next_cycle();
    reset = 1'b0;
    settle();
    check_val("mr_post_pending", 32'(pending), 32'd0);
    check_val("mr_post_hazard", 32'(hazard), 32'd0);
    check_val("mr_post_we", 32'(we), 32'd0);
    next_cycle();
    settle();
    check_val("mr_post_we2", 32'(we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
